// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default
// latencies and controller states, imported by decode, hazard unit and mdu.
package mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_if.sv
// Operand/request and HI/LO/busy bundle between the E stage and the mdu.
interface mdu_if;
  logic        req;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output req, op, a, b, input busy, hi, lo);
  modport slave  (input req, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO. The result is computed from
// the operands at the accept edge and committed when the busy countdown ends.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_t state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0] pend_hi_reg, pend_hi_next;
  logic [31:0] pend_lo_reg, pend_lo_next;
  logic        pend_wr_reg, pend_wr_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_b;
  logic [31:0] quo_u, rem_u;
  logic [31:0] mag_a, mag_b;
  logic [31:0] mag_q, mag_r;
  logic [31:0] quo_s, rem_s;

  assign prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  // Divisor forced to 1 on b==0 so the divider never sees zero; that result is discarded.
  assign div_b = (bus.b == 32'd0) ? 32'd1 : bus.b;
  assign quo_u = bus.a / div_b;
  assign rem_u = bus.a % div_b;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign mag_a = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
  assign mag_b = div_b[31] ? (~div_b + 32'd1) : div_b;
  assign mag_q = mag_a / mag_b;
  assign mag_r = mag_a % mag_b;
  assign quo_s = (bus.a[31] ^ div_b[31]) ? (~mag_q + 32'd1) : mag_q;
  assign rem_s = bus.a[31] ? (~mag_r + 32'd1) : mag_r;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    pend_wr_next = pend_wr_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    case (state_reg)
      IDLE: begin
        if (!bus.req) begin
          case (bus.op)
            MDU_MULT: begin
              state_next   = RUN;
              count_next   = CNT_W'(MULT_CYCLES);
              pend_hi_next = prod_s[63:32];
              pend_lo_next = prod_s[31:0];
              pend_wr_next = 1'b1;
            end
            MDU_MULTU: begin
              state_next   = RUN;
              count_next   = CNT_W'(MULT_CYCLES);
              pend_hi_next = prod_u[63:32];
              pend_lo_next = prod_u[31:0];
              pend_wr_next = 1'b1;
            end
            MDU_DIV: begin
              state_next   = RUN;
              count_next   = CNT_W'(DIV_CYCLES);
              pend_hi_next = rem_s;
              pend_lo_next = quo_s;
              pend_wr_next = (bus.b != 32'd0);
            end
            MDU_DIVU: begin
              state_next   = RUN;
              count_next   = CNT_W'(DIV_CYCLES);
              pend_hi_next = rem_u;
              pend_lo_next = quo_u;
              pend_wr_next = (bus.b != 32'd0);
            end
            MDU_MTHI: hi_next = bus.a;
            MDU_MTLO: lo_next = bus.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (count_reg == CNT_W'(1)) begin
          state_next = IDLE;
          count_next = '0;
          if (pend_wr_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      pend_wr_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      pend_wr_reg <= pend_wr_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit for the E stage of the P7 pipelined MIPS core.
- Executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers.
- Its hi/lo outputs feed the E-stage result 8:1 select, which implements mfhi/mflo.
- Its busy output drives the hazard unit, which stalls any following MDU instruction.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be at least 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be at least 1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state.
- req  in  1  an exception or interrupt is being taken this cycle; suppresses the op presented this cycle.
- op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- a  in  32  rs operand.
- b  in  32  rt operand.
- busy  out  1  an operation is in flight.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (reset==0 at an edge): busy=0, hi=0, lo=0, cycle counter=0, pending result=0.
- Reset overrides every other input, including while an op is in flight; the in-flight op is discarded.
- An op is "accepted" at an edge when reset==1, req==0, busy==0 and op is 1–6.
- Any op presented while busy==1 is ignored. The hazard unit guarantees stall, but the block does not rely on it.
- Any op presented with req==1 is ignored, including mthi/mtlo.
- req does not abort an op already in flight; that op completes normally.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down to 1.
  - IDLE->RUN on an accepted mult/multu/div/divu.
  - RUN->IDLE on the edge where the counter equals 1; hi/lo take the pending result on that same edge.
- Latency: op accepted at edge T → busy=1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) → hi/lo show the new values and busy=0 from the start of cycle T+N+1 onward.
- The result is computed from a and b captured at the accept edge. Operand changes during RUN have no effect.
- mult: signed 32x32→64; hi=product[63:32], lo=product[31:0].
- multu: the same, unsigned.
- div: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - Special case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (b==0, div or divu): still RUN for DIV_CYCLES; hi/lo are left unchanged at completion.
- mthi: hi=a at the accept edge, lo unchanged, busy stays 0.
- mtlo: lo=a at the accept edge, hi unchanged, busy stays 0.
- hi/lo change only at a completion edge, an accepted mthi/mtlo edge, or reset. They are stable at all other times and during RUN.
- Back-to-back: a new op may be accepted on the first cycle where busy==0, i.e. the cycle after completion.

Decomposition:
- Shared package mdu_pkg holds:
  - the op encoding constants (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO);
  - the default latencies;
  - the IDLE/RUN state constants.
- The decode stage and the hazard unit import the same package.
- No sub-module. The arithmetic uses the synthesis operators on the captured operands, which keeps the block self-contained.

Test Plan:
- multu, a=0xFFFFFFFF, b=2, req=0 → busy=1 for 5 cycles, then hi=0x00000001, lo=0xFFFFFFFE, busy=0.
- mult with the same operands → hi=0xFFFFFFFF, lo=0xFFFFFFFE after 5 busy cycles. Then div a=0xFFFFFFF9 (-7), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu a=7, b=2 → lo=3, hi=1.
- Overflow and divide by zero:
  - div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - Then mthi a=0x1234, mtlo a=0x5678, then divu b=0 → busy for 10 cycles, hi=0x1234 and lo=0x5678 unchanged.
- mult presented with req=1 → busy stays 0 and hi/lo unchanged. mtlo a=0xAA with req=1 → lo unchanged. The same mtlo with req=0 → lo=0xAA on the next edge.
- div in flight:
  - req=1 at cycle 3 and mult presented at cycle 4 → the mult is ignored and the div completes normally at cycle 10.
  - A separate run with reset=0 at cycle 5 of a div → busy=0, hi=0, lo=0 on the following cycle, with no later commit.
- Back-to-back: mult completes, and multu is presented on the first cycle after busy falls → accepted immediately, busy rises on the next edge, results correct.
